i_cntrl: RTL and testbench

// Instruction-cache controller between the fetch stage, the Icache SRAM and instruction memory.
// - Fetch hits return the selected instruction word in the same cycle.
// - Misses stall fetch, read one block from imem and write it into Icache.
// - After the fill, the fetch is replayed as a hit.
// - Exposes hit/miss event counters for performance measurement.

---
 rtl/i_cntrl_if.sv | 52 +++++
 rtl/i_cntrl.sv | 132 +++++++++++++
 tb/tb_i_cntrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/i_cntrl_if.sv
// i_cntrl_if: bundles the three buses around the instruction-cache controller.
//   fetch side : ren, pc (to controller); stall, instr (from controller)
//   Icache side: cacheEn, cacheMemWen, cacheBlockAddr, cacheDin (from controller);
//                cacheHit, cacheDout (to controller, combinational on en/addr)
//   imem side  : memRen, memBlockAddr (from controller); memReady, memDout (to controller)
//   perf/debug : hit_count, miss_count, dbg_state (from controller)
// Handshakes: a fetch completes in any cycle where ren=1 and stall=0; while
// stall=1 the fetch stage holds pc and retries. An imem read is requested while
// memRen=1 and completes in the first cycle where memRen=1 and memReady=1;
// memReady outside a request is ignored.
// Modports: master = the controller, slave = fetch stage / Icache / imem side.
interface i_cntrl_if #(
  parameter int WORD_BITS     = 32,
  parameter int BLOCK_WORDS   = 4,
  parameter int PC_BITS       = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter int CNT_BITS      = 32
) ();
  localparam int WORD_SEL_BITS = $clog2(BLOCK_WORDS);
  localparam int BLK_ADDR_BITS = PC_BITS - 2 - WORD_SEL_BITS;
  localparam int BLOCK_BITS    = WORD_BITS * BLOCK_WORDS;

  logic                     ren;
  logic [PC_BITS-1:0]       pc;
  logic                     stall;
  logic [WORD_BITS-1:0]     instr;
  logic                     cacheEn;
  logic                     cacheMemWen;
  logic [BLK_ADDR_BITS-1:0] cacheBlockAddr;
  logic [BLOCK_BITS-1:0]    cacheDin;
  logic                     cacheHit;
  logic [BLOCK_BITS-1:0]    cacheDout;
  logic                     memRen;
  logic [MEM_ADDR_BITS-1:0] memBlockAddr;
  logic                     memReady;
  logic [BLOCK_BITS-1:0]    memDout;
  logic [CNT_BITS-1:0]      hit_count;
  logic [CNT_BITS-1:0]      miss_count;
  logic [1:0]               dbg_state;

  modport master (
    input  ren, pc, cacheHit, cacheDout, memReady, memDout,
    output stall, instr, cacheEn, cacheMemWen, cacheBlockAddr, cacheDin,
           memRen, memBlockAddr, hit_count, miss_count, dbg_state
  );

  modport slave (
    output ren, pc, cacheHit, cacheDout, memReady, memDout,
    input  stall, instr, cacheEn, cacheMemWen, cacheBlockAddr, cacheDin,
           memRen, memBlockAddr, hit_count, miss_count, dbg_state
  );
endinterface

// File: rtl/i_cntrl.sv
// i_cntrl: instruction-cache controller between fetch, the Icache SRAM and imem.
// Hits return the selected word in the same cycle. A miss stalls fetch, reads
// one block from imem, writes it into the Icache, then returns to IDLE where the
// held pc looks up again and hits.
// Ports:
//   clock : single clock, all state on the rising edge
//   reset : synchronous, active-low (0 = reset)
//   bus   : i_cntrl_if.master (fetch, Icache, imem, counters, dbg_state)
// dbg_state encoding: 0 = IDLE, 1 = MEM_WAIT, 2 = FILL.
// BLOCK_WORDS must be a power of two and at least 2.
module i_cntrl #(
  parameter int WORD_BITS     = 32,
  parameter int BLOCK_WORDS   = 4,
  parameter int PC_BITS       = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter int CNT_BITS      = 32
) (
  input  logic     clock,
  input  logic     reset,
  i_cntrl_if.master bus
);
  localparam int WORD_SEL_BITS = $clog2(BLOCK_WORDS);
  localparam int BLK_ADDR_BITS = PC_BITS - 2 - WORD_SEL_BITS;
  localparam int BLOCK_BITS    = WORD_BITS * BLOCK_WORDS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FILL     = 2'd2
  } state_t;

  state_t                   state;
  logic [BLK_ADDR_BITS-1:0] miss_addr;
  logic [BLOCK_BITS-1:0]    fill_buf;
  logic [CNT_BITS-1:0]      hit_cnt;
  logic [CNT_BITS-1:0]      miss_cnt;

  // Fetch address fields; the byte offset pc[1:0] is not used.
  logic [BLK_ADDR_BITS-1:0] blk;
  logic [WORD_SEL_BITS-1:0] word;
  logic                     unused_pc_bits;
  assign blk            = bus.pc[PC_BITS-1 : 2+WORD_SEL_BITS];
  assign word           = bus.pc[2+WORD_SEL_BITS-1 : 2];
  assign unused_pc_bits = ^bus.pc[1:0];

  // Word view of the cache block, word 0 in the least significant bits.
  logic [BLOCK_WORDS-1:0][WORD_BITS-1:0] dout_words;
  assign dout_words = bus.cacheDout;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      miss_addr <= '0;
      fill_buf  <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ren) begin
            if (bus.cacheHit) begin
              hit_cnt <= hit_cnt + CNT_BITS'(1);
            end else begin
              miss_cnt  <= miss_cnt + CNT_BITS'(1);
              miss_addr <= blk;
              state     <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          // Only the first memReady cycle is taken; leaving the state drops memRen.
          if (bus.memReady) begin
            fill_buf <= bus.memDout;
            state    <= FILL;
          end
        end
        FILL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and inputs rather than registered, because
  // a hit must return its word in the same cycle as the request.
  logic                     stall_o;
  logic [WORD_BITS-1:0]     instr_o;
  logic                     cache_en_o;
  logic                     cache_wen_o;
  logic [BLK_ADDR_BITS-1:0] cache_addr_o;
  logic                     mem_ren_o;

  always_comb begin
    stall_o      = 1'b1;
    instr_o      = '0;
    cache_en_o   = 1'b0;
    cache_wen_o  = 1'b0;
    cache_addr_o = blk;
    mem_ren_o    = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          cache_en_o = bus.ren;
          if (!bus.ren) begin
            stall_o = 1'b0;
          end else if (bus.cacheHit) begin
            stall_o = 1'b0;
            instr_o = dout_words[word];
          end
        end
        MEM_WAIT: mem_ren_o = 1'b1;
        FILL: begin
          cache_en_o   = 1'b1;
          cache_wen_o  = 1'b1;
          cache_addr_o = miss_addr;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall          = stall_o;
  assign bus.instr          = instr_o;
  assign bus.cacheEn        = cache_en_o;
  assign bus.cacheMemWen    = cache_wen_o;
  assign bus.cacheBlockAddr = cache_addr_o;
  assign bus.cacheDin       = fill_buf;
  assign bus.memRen         = mem_ren_o;
  assign bus.memBlockAddr   = miss_addr[MEM_ADDR_BITS-1:0];
  assign bus.hit_count      = hit_cnt;
  assign bus.miss_count     = miss_cnt;
  assign bus.dbg_state      = state;
endmodule

// File: tb/tb_i_cntrl.sv
module tb_i_cntrl;
  // Clock / reset
  logic clock = 1'b0;
  logic reset;
  logic reset2;
  always #5 clock = ~clock;

  i_cntrl_if #(.CNT_BITS(32)) b1 ();
  i_cntrl_if #(.CNT_BITS(4))  b2 ();

  i_cntrl #(.CNT_BITS(32)) dut (.clock(clock), .reset(reset),  .bus(b1));
  i_cntrl #(.CNT_BITS(4))  dut_small (.clock(clock), .reset(reset2), .bus(b2));

  // Icache model for dut: 16 direct-mapped lines indexed by block address bits [3:0]
  logic         line_valid [16] = '{default: 1'b0};
  logic [27:0]  line_tag   [16] = '{default: 28'd0};
  logic [127:0] line_data  [16] = '{default: 128'd0};
  logic [3:0]   idx;
  int           wen_cycles    = 0;
  int           memren_cycles = 0;

  assign idx = b1.cacheBlockAddr[3:0];
  always_comb begin
    b1.cacheHit  = b1.cacheEn && line_valid[idx] && (line_tag[idx] == b1.cacheBlockAddr);
    b1.cacheDout = line_data[idx];
  end
  always @(posedge clock) begin
    if (b1.cacheMemWen) begin
      line_valid[idx] <= 1'b1;
      line_tag[idx]   <= b1.cacheBlockAddr;
      line_data[idx]  <= b1.cacheDin;
      wen_cycles      <= wen_cycles + 1;
    end
    if (b1.memRen) memren_cycles <= memren_cycles + 1;
  end

  // dut_small sees a cache that always hits with a fixed block
  localparam logic [127:0] SMALL_BLK = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
  always_comb begin
    b2.cacheHit  = b2.cacheEn;
    b2.cacheDout = SMALL_BLK;
  end

  // Scoreboard
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: advance to just after the next rising edge
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  localparam logic [31:0]  W0 = 32'h0000_0013;
  localparam logic [31:0]  W1 = 32'h0010_0093;
  localparam logic [31:0]  W2 = 32'h0020_0113;
  localparam logic [31:0]  W3 = 32'h0030_0193;
  localparam logic [127:0] BLK = {W3, W2, W1, W0};
  localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};

  int stalls;

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    b1.ren = 1'b1; b1.pc = 32'h0; b1.memReady = 1'b0; b1.memDout = '0;
    b2.ren = 1'b0; b2.pc = 32'h8; b2.memReady = 1'b0; b2.memDout = '0;

    // 1. reset held for two edges with ren=1
    cyc(); cyc(); #1;
    chk("rst_stall",  b1.stall, 1);
    chk("rst_memren", b1.memRen, 0);
    chk("rst_cen",    b1.cacheEn, 0);
    chk("rst_wen",    b1.cacheMemWen, 0);
    chk("rst_instr",  b1.instr, 0);
    chk("rst_hits",   b1.hit_count, 0);
    chk("rst_miss",   b1.miss_count, 0);
    chk("rst_state",  b1.dbg_state, 0);
    reset = 1'b1; b1.ren = 1'b0; #1;
    chk("rel_state", b1.dbg_state, 0);
    chk("rel_stall", b1.stall, 0);

    // 2. cold miss at pc=0x100, memReady on third MEM_WAIT cycle
    cyc(); b1.ren = 1'b1; b1.pc = 32'h100; #1;
    stalls = int'(b1.stall);
    chk("miss_stall", b1.stall, 1);
    cyc(); #1;
    stalls += int'(b1.stall);
    chk("mw_state",  b1.dbg_state, 1);
    chk("mw_memren", b1.memRen, 1);
    chk("mw_addr",   b1.memBlockAddr, 10'h10);
    chk("mw_cen",    b1.cacheEn, 0);
    chk("mw_misses", b1.miss_count, 1);
    cyc(); #1;
    stalls += int'(b1.stall);
    cyc(); b1.memReady = 1'b1; b1.memDout = BLK; #1;
    stalls += int'(b1.stall);
    chk("mw3_memren", b1.memRen, 1);
    cyc(); b1.memReady = 1'b0; b1.memDout = JUNK; #1;
    stalls += int'(b1.stall);
    chk("fill_state",  b1.dbg_state, 2);
    chk("fill_wen",    b1.cacheMemWen, 1);
    chk("fill_cen",    b1.cacheEn, 1);
    chk("fill_addr",   b1.cacheBlockAddr, 28'h10);
    chk("fill_din",    b1.cacheDin, BLK);
    chk("fill_memren", b1.memRen, 0);
    cyc(); #1;
    chk("replay_stall", b1.stall, 0);
    chk("replay_instr", b1.instr, W0);
    chk("stall_cycles", stalls, 5);

    // 3. sequential hits within the block
    cyc(); b1.pc = 32'h104; #1;
    chk("hits_after_replay", b1.hit_count, 1);
    chk("miss_after_replay", b1.miss_count, 1);
    chk("instr_w1", b1.instr, W1);
    chk("stall_w1", b1.stall, 0);
    cyc(); b1.pc = 32'h108; #1;
    chk("instr_w2", b1.instr, W2);
    cyc(); b1.pc = 32'h10C; #1;
    chk("instr_w3", b1.instr, W3);
    chk("stall_w3", b1.stall, 0);
    cyc(); b1.ren = 1'b0; #1;
    chk("hits_4",        b1.hit_count, 4);
    chk("memren_cycles", memren_cycles, 3);
    chk("wen_cycles",    wen_cycles, 1);

    // 4. reset during MEM_WAIT, late memReady ignored
    b1.ren = 1'b1; b1.pc = 32'h200; #1;
    chk("miss2_stall", b1.stall, 1);
    cyc(); #1;
    chk("mw2_state",  b1.dbg_state, 1);
    chk("mw2_memren", b1.memRen, 1);
    chk("mw2_addr",   b1.memBlockAddr, 10'h20);
    reset = 1'b0; #1;
    chk("mwrst_memren", b1.memRen, 0);
    chk("mwrst_stall",  b1.stall, 1);
    cyc(); reset = 1'b1; b1.ren = 1'b0; b1.memReady = 1'b1; b1.memDout = JUNK; #1;
    chk("abort_state",  b1.dbg_state, 0);
    chk("abort_memren", b1.memRen, 0);
    chk("abort_wen",    b1.cacheMemWen, 0);
    chk("abort_misses", b1.miss_count, 0);
    cyc(); b1.memReady = 1'b0; #1;
    chk("late_state",  b1.dbg_state, 0);
    chk("late_wen",    wen_cycles, 1);
    chk("late_memren", memren_cycles, 3);

    // 5. ren=0 with a memReady pulse
    b1.ren = 1'b1; b1.pc = 32'h108; #1;
    chk("rehit_instr", b1.instr, W2);
    chk("rehit_stall", b1.stall, 0);
    cyc(); b1.ren = 1'b0; b1.pc = 32'h300; b1.memReady = 1'b1; b1.memDout = JUNK; #1;
    chk("idle_stall",  b1.stall, 0);
    chk("idle_instr",  b1.instr, 0);
    chk("idle_cen",    b1.cacheEn, 0);
    chk("idle_memren", b1.memRen, 0);
    cyc(); b1.memReady = 1'b0; #1;
    chk("idle_state", b1.dbg_state, 0);
    chk("idle_hits",  b1.hit_count, 1);
    chk("idle_miss",  b1.miss_count, 0);

    // 6. 4-bit counters wrap after 16 hits
    chk("small_rst_hits", b2.hit_count, 0);
    reset2 = 1'b1; b2.ren = 1'b1; #1;
    chk("small_instr", b2.instr, 32'hD2);
    chk("small_stall", b2.stall, 0);
    for (int i = 0; i < 15; i++) cyc();
    #1;
    chk("small_hits_15", b2.hit_count, 4'd15);
    cyc(); #1;
    chk("small_hits_wrap", b2.hit_count, 4'd0);
    chk("small_miss",      b2.miss_count, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
